// File: rtl/fetch_front.sv
// Instruction-fetch front end: PC register, IF/ID pipeline register, local J/JAL
// resolution, execute-stage redirect and the nop-muxed instruction seen by hazard logic.
module fetch_front #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pcEnable,
    input  logic        regIF_en,
    input  logic        nopMux,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc4,
    output logic        if_valid,
    output logic [7:0]  stall_count
);

    logic [31:0] pc_r;
    logic [31:0] ifid_instr_r;
    logic [31:0] ifid_pc4_r;
    logic        ifid_valid_r;
    logic [7:0]  stall_count_r;

    logic [31:0] pc4_s;
    logic        jmp_s;
    logic [31:0] jmp_target_s;
    logic [31:0] pc_next_s;
    logic [31:0] ifid_instr_next_s;
    logic [31:0] ifid_pc4_next_s;
    logic        ifid_valid_next_s;
    logic [7:0]  stall_count_next_s;

    // Next-state selection: redirect beats a local jump, which beats the normal update.
    always_comb begin
        pc4_s              = pc_r + 32'd4;
        jmp_s              = ifid_valid_r & regIF_en &
                             ((ifid_instr_r[31:26] == 6'h02) | (ifid_instr_r[31:26] == 6'h03));
        jmp_target_s       = {ifid_pc4_r[31:28], ifid_instr_r[25:0], 2'b00};
        pc_next_s          = pc_r;
        ifid_instr_next_s  = ifid_instr_r;
        ifid_pc4_next_s    = ifid_pc4_r;
        ifid_valid_next_s  = ifid_valid_r;
        stall_count_next_s = stall_count_r;
        if (redirect_valid) begin
            pc_next_s         = {redirect_pc[31:2], 2'b00};
            ifid_instr_next_s = NOP_WORD;
            ifid_valid_next_s = 1'b0;
        end else if (jmp_s) begin
            // The word fetched sequentially behind the jump is squashed.
            pc_next_s         = jmp_target_s;
            ifid_instr_next_s = NOP_WORD;
            ifid_valid_next_s = 1'b0;
        end else begin
            if (pcEnable) begin
                pc_next_s = pc4_s;
            end else begin
                pc_next_s = pc_r;
            end
            if (regIF_en) begin
                ifid_instr_next_s = imem_rdata;
                ifid_pc4_next_s   = pc4_s;
                ifid_valid_next_s = 1'b1;
            end else begin
                ifid_instr_next_s = ifid_instr_r;
                ifid_pc4_next_s   = ifid_pc4_r;
                ifid_valid_next_s = ifid_valid_r;
            end
        end
        if (!pcEnable && !redirect_valid && !jmp_s && (stall_count_r != 8'hFF)) begin
            stall_count_next_s = stall_count_r + 8'd1;
        end else begin
            stall_count_next_s = stall_count_r;
        end
    end

    // PC, IF/ID and stall counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_r          <= RESET_PC;
            ifid_instr_r  <= NOP_WORD;
            ifid_pc4_r    <= 32'h0000_0000;
            ifid_valid_r  <= 1'b0;
            stall_count_r <= 8'h00;
        end else begin
            pc_r          <= pc_next_s;
            ifid_instr_r  <= ifid_instr_next_s;
            ifid_pc4_r    <= ifid_pc4_next_s;
            ifid_valid_r  <= ifid_valid_next_s;
            stall_count_r <= stall_count_next_s;
        end
    end

    // Bubble insertion acts on the outputs only; the held instruction is preserved.
    always_comb begin
        imem_addr   = pc_r;
        if_pc4      = ifid_pc4_r;
        stall_count = stall_count_r;
        if (nopMux) begin
            if_instr = NOP_WORD;
            if_valid = 1'b0;
        end else begin
            if_instr = ifid_instr_r;
            if_valid = ifid_valid_r;
        end
    end

endmodule
